// File: rtl/parking_pkg.sv
// Shared types and constants for the parking gate controller and the
// occupancy board it feeds.
package parking_pkg;

  localparam int DEBOUNCE_DEF     = 3;
  localparam int OPEN_TIMEOUT_DEF = 16;
  localparam int CAPACITY         = 700;

  typedef enum logic [2:0] {
    L_IDLE,
    L_CHECK,
    L_OPEN,
    L_PASSING,
    L_EMIT,
    L_DENY,
    L_WAIT_CLEAR
  } lane_state_t;

endpackage

// File: rtl/parking_gate_ctrl_gate_lane.sv
// One barrier lane: detect debounce, admission check, open timeout,
// pass-through tracking and tailgate detection.
module gate_lane
  import parking_pkg::*;
#(
  parameter int DEBOUNCE     = DEBOUNCE_DEF,
  parameter int OPEN_TIMEOUT = OPEN_TIMEOUT_DEF,
  parameter bit CHECK_SPACE  = 1'b1
) (
  input  logic clk,
  input  logic i_rst,
  input  logic i_detect,
  input  logic i_is_uni,
  input  logic i_pass,
  input  logic i_admit,
  output logic o_cls,
  output logic o_gate_open,
  output logic o_event,
  output logic o_denied,
  output logic o_alarm
);

  localparam int DW = $clog2(DEBOUNCE + 1);
  localparam int TW = $clog2(OPEN_TIMEOUT + 1);
  localparam logic [DW-1:0] DB_LAST = DW'(DEBOUNCE - 1);
  localparam logic [DW-1:0] DB_MAX  = DW'(DEBOUNCE);
  localparam logic [TW-1:0] TO_LAST = TW'(OPEN_TIMEOUT - 1);
  localparam logic [TW-1:0] TO_MAX  = TW'(OPEN_TIMEOUT);

  lane_state_t   r_state;
  lane_state_t   w_next;
  logic [DW-1:0] r_db_cnt;
  logic [TW-1:0] r_to_cnt;
  logic          r_cls;
  logic          r_pass_q;
  logic          w_db_hit;

  // The edge that brings the count to DEBOUNCE is the edge into CHECK
  assign w_db_hit = i_detect && (r_db_cnt == DB_LAST);

  always_ff @(posedge clk) begin
    if (i_rst) r_state <= L_IDLE;
    else       r_state <= w_next;
  end

  always_ff @(posedge clk) begin
    if (i_rst) begin
      r_db_cnt <= '0;
      r_to_cnt <= '0;
      r_cls    <= 1'b0;
      r_pass_q <= 1'b0;
    end else begin
      r_pass_q <= i_pass;
      if (r_state == L_IDLE && i_detect) begin
        if (r_db_cnt != DB_MAX) r_db_cnt <= r_db_cnt + DW'(1);
      end else begin
        r_db_cnt <= '0;
      end
      if (r_state == L_OPEN) begin
        if (r_to_cnt != TO_MAX) r_to_cnt <= r_to_cnt + TW'(1);
      end else begin
        r_to_cnt <= '0;
      end
      if (r_state == L_IDLE && w_db_hit) r_cls <= i_is_uni;
    end
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      L_IDLE:       if (w_db_hit) w_next = L_CHECK;
      L_CHECK:      w_next = (!CHECK_SPACE || i_admit) ? L_OPEN : L_DENY;
      L_OPEN: begin
        if (i_pass)                   w_next = L_PASSING;
        else if (r_to_cnt == TO_LAST) w_next = L_WAIT_CLEAR;
      end
      L_PASSING:    if (!i_pass) w_next = L_EMIT;
      L_EMIT:       w_next = L_WAIT_CLEAR;
      L_DENY:       w_next = L_WAIT_CLEAR;
      L_WAIT_CLEAR: if (!i_detect) w_next = L_IDLE;
      default:      w_next = L_IDLE;
    endcase
  end

  always_comb begin
    o_cls       = r_cls;
    o_gate_open = (r_state == L_OPEN) || (r_state == L_PASSING);
    o_event     = (r_state == L_EMIT);
    o_denied    = (r_state == L_DENY);
    o_alarm     = (r_state == L_IDLE) && i_pass && !r_pass_q;
  end

endmodule

// File: rtl/parking_gate_ctrl.sv
// Entry/exit lane wrapper: admission decision from the board's vacancy
// flags plus event class qualification.
module parking_gate_ctrl
  import parking_pkg::*;
#(
  parameter int DEBOUNCE     = DEBOUNCE_DEF,
  parameter int OPEN_TIMEOUT = OPEN_TIMEOUT_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic entry_detect,
  input  logic entry_is_uni,
  input  logic entry_pass,
  input  logic exit_detect,
  input  logic exit_is_uni,
  input  logic exit_pass,
  input  logic uni_is_vacated_space,
  input  logic is_vacated_space,
  output logic car_entered,
  output logic is_uni_car_entered,
  output logic car_exited,
  output logic is_uni_car_exited,
  output logic entry_gate_open,
  output logic exit_gate_open,
  output logic entry_denied,
  output logic tailgate_alarm
);

  logic w_en_cls, w_en_evt, w_en_den, w_en_alm;
  logic w_ex_cls, w_ex_evt, w_ex_den, w_ex_alm;
  logic w_en_admit;

  assign w_en_admit = w_en_cls
                    ? (uni_is_vacated_space | is_vacated_space)
                    : is_vacated_space;

  gate_lane #(
    .DEBOUNCE     (DEBOUNCE),
    .OPEN_TIMEOUT (OPEN_TIMEOUT),
    .CHECK_SPACE  (1'b1)
  ) u_entry (
    .clk         (clk),
    .i_rst       (reset),
    .i_detect    (entry_detect),
    .i_is_uni    (entry_is_uni),
    .i_pass      (entry_pass),
    .i_admit     (w_en_admit),
    .o_cls       (w_en_cls),
    .o_gate_open (entry_gate_open),
    .o_event     (w_en_evt),
    .o_denied    (w_en_den),
    .o_alarm     (w_en_alm)
  );

  gate_lane #(
    .DEBOUNCE     (DEBOUNCE),
    .OPEN_TIMEOUT (OPEN_TIMEOUT),
    .CHECK_SPACE  (1'b0)
  ) u_exit (
    .clk         (clk),
    .i_rst       (reset),
    .i_detect    (exit_detect),
    .i_is_uni    (exit_is_uni),
    .i_pass      (exit_pass),
    .i_admit     (1'b1),
    .o_cls       (w_ex_cls),
    .o_gate_open (exit_gate_open),
    .o_event     (w_ex_evt),
    .o_denied    (w_ex_den),
    .o_alarm     (w_ex_alm)
  );

  assign car_entered        = w_en_evt;
  assign is_uni_car_entered = w_en_evt & w_en_cls;
  assign car_exited         = w_ex_evt;
  assign is_uni_car_exited  = w_ex_evt & w_ex_cls;
  // The exit lane skips the space check, so its deny term is always 0
  assign entry_denied       = w_en_den | w_ex_den;
  assign tailgate_alarm     = w_en_alm | w_ex_alm;

endmodule

// File: tb/tb_parking_gate_ctrl.sv
// Scenario-driven random bench: each lane's expected waveform is derived
// arithmetically from the car's arrival, pass and release times.
module tb_parking_gate_ctrl;

  localparam int N  = 44;
  localparam int DB = 3;
  localparam int TO = 16;

  logic clk = 1'b0;
  logic reset;
  logic entry_detect, entry_is_uni, entry_pass;
  logic exit_detect, exit_is_uni, exit_pass;
  logic uni_is_vacated_space, is_vacated_space;
  logic car_entered, is_uni_car_entered;
  logic car_exited, is_uni_car_exited;
  logic entry_gate_open, exit_gate_open;
  logic entry_denied, tailgate_alarm;

  always #5 clk = ~clk;

  parking_gate_ctrl dut (
    .clk                  (clk),
    .reset                (reset),
    .entry_detect         (entry_detect),
    .entry_is_uni         (entry_is_uni),
    .entry_pass           (entry_pass),
    .exit_detect          (exit_detect),
    .exit_is_uni          (exit_is_uni),
    .exit_pass            (exit_pass),
    .uni_is_vacated_space (uni_is_vacated_space),
    .is_vacated_space     (is_vacated_space),
    .car_entered          (car_entered),
    .is_uni_car_entered   (is_uni_car_entered),
    .car_exited           (car_exited),
    .is_uni_car_exited    (is_uni_car_exited),
    .entry_gate_open      (entry_gate_open),
    .exit_gate_open       (exit_gate_open),
    .entry_denied         (entry_denied),
    .tailgate_alarm       (tailgate_alarm)
  );

  int checks = 0;
  int errors = 0;
  int scn = 0;
  int cyc = 0;

  bit det[2][N];
  bit uni[2][N];
  bit pas[2][N];
  bit spu[N];
  bit spp[N];
  bit eg[2][N];
  bit ev[2][N];
  bit ec[2][N];
  bit ed[2][N];
  bit ea[2][N];

  task automatic chk(input string tag, input logic obs, input logic exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s scn=%0d cyc=%0d got=%b exp=%b",
               tag, scn, cyc, obs, exp);
    end
  endtask

  task automatic rand_space();
    for (int t = 0; t < N; t++) begin
      spu[t] = 1'($urandom_range(0, 1));
      spp[t] = 1'($urandom_range(0, 1));
    end
  endtask

  // kind: 0 car passes, 1 car backs out, 2 no car (bounce/tailgate only)
  task automatic plan_lane(input int ln, input int kind, input int b,
                           input int tl, input int a, input int n,
                           input int k, input int cls_f,
                           input int spu_f, input int spp_f);
    int s, g, p, e, r;
    bit cl, adm;
    for (int t = 0; t < N; t++) begin
      det[ln][t] = 1'b0;
      pas[ln][t] = 1'b0;
      uni[ln][t] = 1'($urandom_range(0, 1));
      eg[ln][t] = 1'b0;
      ev[ln][t] = 1'b0;
      ec[ln][t] = 1'b0;
      ed[ln][t] = 1'b0;
      ea[ln][t] = 1'b0;
    end
    for (int i = 1; i <= tl; i++) pas[ln][i] = 1'b1;
    if (tl > 0) ea[ln][1] = 1'b1;
    for (int i = 2; i < 2 + b; i++) det[ln][i] = 1'b1;
    if (kind == 2) return;
    s = 3 + b;
    g = s + DB + 1;
    cl = (cls_f < 0) ? 1'($urandom_range(0, 1)) : 1'(cls_f);
    uni[ln][s + DB - 1] = cl;
    if (spu_f >= 0) spu[s + DB] = 1'(spu_f);
    if (spp_f >= 0) spp[s + DB] = 1'(spp_f);
    adm = (ln == 1) || spp[s + DB] || (cl && spu[s + DB]);
    if (!adm) ed[ln][g] = 1'b1;
    if (kind == 0) begin
      for (int i = g + a; i < g + a + n; i++) pas[ln][i] = 1'b1;
      p = g + a + n;
      e = p + 1;
      if (adm) begin
        for (int i = g; i <= p; i++) eg[ln][i] = 1'b1;
        ev[ln][e] = 1'b1;
        ec[ln][e] = cl;
      end
    end else begin
      e = g + TO - 1;
      if (adm) for (int i = g; i <= e; i++) eg[ln][i] = 1'b1;
    end
    r = e + 1 + k;
    for (int i = s; i < r; i++) det[ln][i] = 1'b1;
  endtask

  task automatic run_scn(input int rst_at);
    bit z;
    z = 1'b0;
    for (int t = 0; t < N; t++) begin
      @(posedge clk);
      #1;
      cyc = t;
      if (t == rst_at) z = 1'b1;
      reset = (t == rst_at);
      entry_detect = z ? 1'b0 : det[0][t];
      entry_pass   = z ? 1'b0 : pas[0][t];
      exit_detect  = z ? 1'b0 : det[1][t];
      exit_pass    = z ? 1'b0 : pas[1][t];
      entry_is_uni = uni[0][t];
      exit_is_uni  = uni[1][t];
      uni_is_vacated_space = spu[t];
      is_vacated_space     = spp[t];
      @(negedge clk);
      if (t != rst_at) begin
        chk("entry_gate", entry_gate_open, z ? 1'b0 : eg[0][t]);
        chk("exit_gate", exit_gate_open, z ? 1'b0 : eg[1][t]);
        chk("car_entered", car_entered, z ? 1'b0 : ev[0][t]);
        chk("uni_entered", is_uni_car_entered, z ? 1'b0 : ec[0][t]);
        chk("car_exited", car_exited, z ? 1'b0 : ev[1][t]);
        chk("uni_exited", is_uni_car_exited, z ? 1'b0 : ec[1][t]);
        chk("denied", entry_denied, z ? 1'b0 : ed[0][t]);
        chk("tailgate", tailgate_alarm,
            z ? 1'b0 : (ea[0][t] | ea[1][t]));
      end
    end
    reset = 1'b0;
    scn++;
  endtask

  initial begin
    reset = 1'b1;
    entry_detect = 1'b0;
    entry_is_uni = 1'b0;
    entry_pass = 1'b0;
    exit_detect = 1'b0;
    exit_is_uni = 1'b0;
    exit_pass = 1'b0;
    uni_is_vacated_space = 1'b0;
    is_vacated_space = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("rst_en_gate", entry_gate_open, 1'b0);
    chk("rst_ex_gate", exit_gate_open, 1'b0);
    chk("rst_entered", car_entered, 1'b0);
    chk("rst_uni_en", is_uni_car_entered, 1'b0);
    chk("rst_exited", car_exited, 1'b0);
    chk("rst_uni_ex", is_uni_car_exited, 1'b0);
    chk("rst_denied", entry_denied, 1'b0);
    chk("rst_tailgate", tailgate_alarm, 1'b0);
    @(posedge clk);
    #1 reset = 1'b0;

    // uni entry with space
    rand_space();
    plan_lane(0, 0, 0, 0, 0, 2, 1, 1, 1, -1);
    plan_lane(1, 2, 0, 0, 0, 1, 0, -1, -1, -1);
    run_scn(-1);
    // full lot, public car refused
    rand_space();
    plan_lane(0, 0, 0, 0, 1, 2, 2, 0, -1, 0);
    plan_lane(1, 2, 0, 0, 0, 1, 0, -1, -1, -1);
    run_scn(-1);
    // uni car takes a public space
    rand_space();
    plan_lane(0, 0, 1, 0, 4, 3, 0, 1, 0, 1);
    plan_lane(1, 2, 0, 0, 0, 1, 0, -1, -1, -1);
    run_scn(-1);
    // bounce on entry, tailgate on exit
    rand_space();
    plan_lane(0, 2, 2, 0, 0, 1, 0, -1, -1, -1);
    plan_lane(1, 2, 2, 1, 0, 1, 0, -1, -1, -1);
    run_scn(-1);
    // both lanes time out, detect held after
    rand_space();
    plan_lane(0, 1, 0, 0, 0, 1, 6, -1, -1, 1);
    plan_lane(1, 1, 1, 0, 0, 1, 4, -1, -1, -1);
    run_scn(-1);
    // simultaneous events with different classes
    rand_space();
    plan_lane(0, 0, 1, 0, 3, 2, 2, 1, -1, 1);
    plan_lane(1, 0, 1, 0, 3, 2, 2, 0, -1, -1);
    run_scn(-1);
    // reset while passing: pass high 9..12, reset at 10
    rand_space();
    plan_lane(0, 0, 0, 0, 2, 4, 0, -1, -1, 1);
    plan_lane(1, 2, 0, 0, 0, 1, 0, -1, -1, -1);
    run_scn(10);

    for (int i = 0; i < 30; i++) begin
      rand_space();
      for (int ln = 0; ln < 2; ln++) begin
        plan_lane(ln, $urandom_range(0, 2), $urandom_range(0, 2),
                  $urandom_range(0, 2), $urandom_range(0, 15),
                  $urandom_range(1, 4), $urandom_range(0, 6),
                  -1, -1, -1);
      end
      run_scn(-1);
    end

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/parking_gate_ctrl.md
Name: parking_gate_ctrl

Overview:
- Upstream stage of the parking occupancy board.
- Converts raw entry/exit lane sensors (vehicle detect, university-card reader, pass-through loop) into clean single-cycle `car_entered`/`car_exited` events plus class flags for the board.
- Uses the board's `uni_is_vacated_space`/`is_vacated_space` to admit or deny entering cars, and drives both barrier-open outputs.

Parameters:
- DEBOUNCE, 3: consecutive cycles a detect sensor must read high before a car is recognised.
- OPEN_TIMEOUT, 16: cycles a barrier stays open waiting for pass-loop activity before closing without an event.

Ports:
- clk  in  1  system clock, all logic on rising edge
- reset  in  1  synchronous, active-high reset
- entry_detect  in  1  car present at entry barrier
- entry_is_uni  in  1  university card presented at entry (sampled with detect)
- entry_pass  in  1  entry pass-through loop occupied
- exit_detect  in  1  car present at exit barrier
- exit_is_uni  in  1  university card presented at exit
- exit_pass  in  1  exit pass-through loop occupied
- uni_is_vacated_space  in  1  from board: university space free
- is_vacated_space  in  1  from board: public space free
- car_entered  out  1  one-cycle pulse, car passed entry
- is_uni_car_entered  out  1  class of that car, valid with car_entered, else 0
- car_exited  out  1  one-cycle pulse, car passed exit
- is_uni_car_exited  out  1  class of that car, valid with car_exited, else 0
- entry_gate_open  out  1  entry barrier open command
- exit_gate_open  out  1  exit barrier open command
- entry_denied  out  1  one-cycle pulse, entry refused (no space)
- tailgate_alarm  out  1  one-cycle pulse, pass loop activity with no authorised opening

Behaviour:
- Reset: all outputs 0, both lanes IDLE, counters 0, latched class 0. Reset mid-operation closes the barrier immediately and emits no event.
- Lanes are independent; entry and exit events may pulse in the same cycle.
- Per-lane FSM states: IDLE, CHECK, OPEN, PASSING, EMIT, DENY, WAIT_CLEAR.
- IDLE:
  - The debounce counter increments while detect=1 and clears when detect=0.
  - When the counter reaches DEBOUNCE, the lane goes to CHECK on the next edge and latches is_uni.
  - Pass=1 rising in IDLE produces a tailgate_alarm pulse; the state is unchanged.
- CHECK (1 cycle), entry lane:
  - Uni car is admitted if uni_is_vacated_space | is_vacated_space.
  - Public car is admitted only if is_vacated_space.
  - Admitted -> OPEN; refused -> DENY.
- CHECK, exit lane: always -> OPEN.
- OPEN:
  - gate_open=1; the timeout counter increments each cycle.
  - pass=1 -> PASSING.
  - Counter == OPEN_TIMEOUT-1 with pass=0 -> WAIT_CLEAR, no event (car backed out).
- PASSING: gate_open stays 1 (no timeout); pass=0 -> EMIT.
- EMIT (1 cycle):
  - car_* pulse=1, class output = latched is_uni, gate_open=0.
  - Next state WAIT_CLEAR.
- DENY (1 cycle): entry_denied=1, next state WAIT_CLEAR.
- WAIT_CLEAR: holds until detect=0 for 1 cycle, then IDLE. This prevents one car generating two events.
- Latency:
  - detect high at cycle 0 -> gate_open from cycle DEBOUNCE+1 (cycle 4 with defaults).
  - Pass falls at cycle p -> event pulse in cycle p+1.
- Counter widths: $clog2(DEBOUNCE+1) and $clog2(OPEN_TIMEOUT+1); both saturate and never wrap.
- Space inputs are sampled only in CHECK; changes afterward do not revoke an open gate.

Decomposition:
- Shared package parking_pkg holds:
  - lane_state_t enum
  - default DEBOUNCE/OPEN_TIMEOUT constants
  - a capacity constant of 700, for the board
- Sub-module gate_lane (parameter CHECK_SPACE=1/0) implements one FSM with debounce and timeout; it is instantiated once per lane.
- The top level only wires the lanes and computes the admit signal.

Test Plan:
- Uni entry with space: detect=1, is_uni=1, uni_space=1 for 3 cycles -> gate open at cycle 4; pass 2 cycles -> car_entered=1, is_uni_car_entered=1 for exactly one cycle.
- Full lot: public car, is_vacated_space=0 -> entry_denied pulse, gate never opens; uni car with uni_space=0 but is_vacated_space=1 -> admitted.
- Bounce: detect high 2 cycles, low 1, high 2 -> no CHECK reached, no gate opening.
- Timeout: gate opens, pass never asserts -> gate closes after 16 cycles, no car_entered; lane returns to IDLE only after detect=0.
- Simultaneous: entry and exit passes complete in the same cycle -> car_entered and car_exited both pulse, each with its correct class flag.
- Reset mid-PASSING and tailgate: reset during PASSING -> all outputs 0 next cycle, no event; pass pulse in IDLE -> one tailgate_alarm pulse.
